fetch_prefetch_unit: RTL and testbench

//  Parametrised instruction fetch stage with a DEPTH-entry prefetch FIFO and valid/ready output to decode.

---
 rtl/fetch_prefetch_unit.sv | 183 ++++++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_unit
// Description : Instruction fetch stage. Issues sequential fetches to
//               instruction memory over a req/ack handshake (any latency,
//               including combinational ack), buffers the returned words
//               in a DEPTH-entry prefetch FIFO and presents them to decode
//               through a valid/ready port. A redirect flushes the FIFO,
//               restarts fetch at the new target and squashes any fetch
//               that is still in flight.
// Ports       : clk, rst             clock / synchronous active-high reset
//               imem_req/addr        fetch request and address to memory
//               imem_ack/rdata       completion strobe and returned word
//               redirect_valid/pc    branch redirect pulse and target
//               out_valid/ready      decode handshake for the FIFO head
//               out_instr/out_pc     head instruction and its fetch address
//               count                FIFO occupancy (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_unit #(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 16,
    parameter int                  DEPTH       = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [PC_WIDTH-1:0]      imem_addr,
    input  logic                     imem_ack,
    input  logic [INSTR_WIDTH-1:0]   imem_rdata,
    input  logic                     redirect_valid,
    input  logic [PC_WIDTH-1:0]      redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_WIDTH-1:0]   out_instr,
    output logic [PC_WIDTH-1:0]      out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    // Fetch sequencer states
    localparam logic [1:0] c_ST_IDLE    = 2'd0;  // nothing outstanding
    localparam logic [1:0] c_ST_REQ     = 2'd1;  // live fetch at r_fetch_pc
    localparam logic [1:0] c_ST_DISCARD = 2'd2;  // squashed fetch still pending

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [PC_WIDTH-1:0]    r_fetch_pc;
    logic [PC_WIDTH-1:0]    w_fetch_pc_next;
    logic [PC_WIDTH-1:0]    r_discard_addr;
    logic [c_CNT_W-1:0]     r_count;
    logic [c_CNT_W-1:0]     w_count_next;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic                   w_push;
    logic                   w_pop;

    logic [INSTR_WIDTH-1:0] r_mem_instr [DEPTH];
    logic [PC_WIDTH-1:0]    r_mem_pc    [DEPTH];

    // ------------------------------------------------------------------
    // FIFO handshake qualifiers. A redirect overrides both: the returned
    // word belongs to the abandoned path and the head is being flushed.
    // ------------------------------------------------------------------
    always_comb begin
        w_pop  = (r_count != '0) && out_ready && !redirect_valid;
        w_push = (r_state == c_ST_REQ) && imem_ack && !redirect_valid;

        w_count_next = r_count;
        if (redirect_valid) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next fetch address
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;

        if (redirect_valid) begin
            w_fetch_pc_next = redirect_pc;
        end else if (w_push) begin
            w_fetch_pc_next = r_fetch_pc + 1'b1;
        end

        case (r_state)
            c_ST_IDLE: begin
                // A pop this cycle guarantees a free slot at the next edge.
                if (redirect_valid || (r_count < c_FULL) || w_pop) begin
                    w_state_next = c_ST_REQ;
                end
            end
            c_ST_REQ: begin
                if (redirect_valid) begin
                    // A completing fetch can simply be dropped; one still in
                    // flight must be waited out without keeping its data.
                    w_state_next = imem_ack ? c_ST_REQ : c_ST_DISCARD;
                end else if (imem_ack) begin
                    // Only keep requesting while a slot will still be free,
                    // so a push can never overflow the FIFO.
                    w_state_next = (w_count_next < c_FULL) ? c_ST_REQ : c_ST_IDLE;
                end
            end
            c_ST_DISCARD: begin
                // Once the squashed fetch completes the FIFO is empty, so
                // fetch from the (possibly updated) target immediately.
                if (imem_ack) begin
                    w_state_next = c_ST_REQ;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_fetch_pc     <= RESET_PC;
            r_discard_addr <= '0;
            r_count        <= '0;
            r_rd_ptr       <= '0;
            r_wr_ptr       <= '0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_count    <= w_count_next;

            // The memory still sees the old address until it acknowledges,
            // so remember it while the fetch address moves to the target.
            if (redirect_valid && (r_state == c_ST_REQ) && !imem_ack) begin
                r_discard_addr <= r_fetch_pc;
            end

            if (redirect_valid) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
        end
    end

    // FIFO storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req  = (r_state == c_ST_REQ) || (r_state == c_ST_DISCARD);
    assign imem_addr = (r_state == c_ST_DISCARD) ? r_discard_addr : r_fetch_pc;
    assign out_valid = (r_count != '0);
    // Head fields read as zero when empty so stale entries never leak out.
    assign out_instr = out_valid ? r_mem_instr[r_rd_ptr] : '0;
    assign out_pc    = out_valid ? r_mem_pc[r_rd_ptr]    : '0;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch_unit
// Description : Self-checking bench for fetch_prefetch_unit. A memory model
//               with programmable ack latency feeds the main instance; a
//               second instance with RESET_PC=FE runs on a combinational
//               memory. A queue-based scoreboard tracks what the FIFO must
//               hold, alongside directed scenarios and a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [7:0]  out_pc;
    logic [2:0]  count;

    logic        b_req;
    logic [7:0]  b_addr;
    logic        b_ack;
    logic [15:0] b_rdata;
    logic        b_valid;
    logic [15:0] b_instr;
    logic [7:0]  b_pc;
    logic [2:0]  b_count;
    logic        b_redirect;
    logic [7:0]  b_redirect_pc;
    logic        b_ready;

    int n_checks = 0;
    int n_fail   = 0;

    int lat_min = 0;
    int lat_max = 0;
    int mem_wait = 0;
    int mem_lat  = 0;

    // Instruction content is a fixed function of its address.
    function automatic logic [15:0] instr_of(input logic [7:0] a);
        return {a ^ 8'h5A, ~a};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    fetch_prefetch_unit #(
        .PC_WIDTH(8), .INSTR_WIDTH(16), .DEPTH(DEPTH), .RESET_PC(8'h00)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .count(count)
    );

    fetch_prefetch_unit #(
        .PC_WIDTH(8), .INSTR_WIDTH(16), .DEPTH(DEPTH), .RESET_PC(8'hFE)
    ) dut_b (
        .clk(clk), .rst(rst),
        .imem_req(b_req), .imem_addr(b_addr),
        .imem_ack(b_ack), .imem_rdata(b_rdata),
        .redirect_valid(b_redirect), .redirect_pc(b_redirect_pc),
        .out_valid(b_valid), .out_ready(b_ready),
        .out_instr(b_instr), .out_pc(b_pc), .count(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with latency: ack rises after req has been high mem_lat cycles.
    assign imem_ack   = imem_req && (mem_wait >= mem_lat);
    assign imem_rdata = instr_of(imem_addr);

    always @(posedge clk) begin
        if (rst) begin
            mem_wait <= 0;
            mem_lat  <= lat_min;
        end else if (imem_req) begin
            if (imem_ack) begin
                mem_wait <= 0;
                mem_lat  <= int'($urandom_range(lat_max, lat_min));
            end else begin
                mem_wait <= mem_wait + 1;
            end
        end
    end

    assign b_ack         = b_req;
    assign b_rdata       = instr_of(b_addr);
    assign b_redirect    = 1'b0;
    assign b_redirect_pc = 8'h00;
    assign b_ready       = 1'b1;

    // ------------------------------------------------------------------
    // Scoreboard: the FIFO must hold exactly the addresses fetched on the
    // current path, in order. Sampled at negedge; inputs are stable from
    // here until the next rising edge, so the update models that edge.
    // ------------------------------------------------------------------
    logic [7:0] m_q[$];
    logic [7:0] m_fetch;
    logic [7:0] m_prev_addr;
    bit         m_on = 1'b0;
    bit         m_stale = 1'b0;
    bit         m_prev_pend = 1'b0;
    int         m_stall = 0;

    always @(negedge clk) begin
        if (m_on) begin
            check("sb_valid", 32'(out_valid), 32'(m_q.size() != 0));
            check("sb_count", 32'(count), 32'(m_q.size()));
            if (m_q.size() != 0) begin
                check("sb_pc", 32'(out_pc), 32'(m_q[0]));
                check("sb_instr", 32'(out_instr), 32'(instr_of(m_q[0])));
            end
            if (imem_req && !m_stale) begin
                check("sb_addr", 32'(imem_addr), 32'(m_fetch));
            end
            if (m_prev_pend) begin
                check("hold_req", 32'(imem_req), 32'd1);
                check("hold_addr", 32'(imem_addr), 32'(m_prev_addr));
            end
            if (m_q.size() == DEPTH) begin
                check("full_noreq", 32'(imem_req), 32'd0);
            end
            check("progress", 32'(m_stall > 16), 32'd0);
        end

        if (rst) begin
            m_on        = 1'b1;
            m_q.delete();
            m_fetch     = 8'h00;
            m_stale     = 1'b0;
            m_prev_pend = 1'b0;
            m_stall     = 0;
        end else if (m_on) begin
            bit pushed;
            pushed = 1'b0;
            if (redirect_valid) begin
                m_q.delete();
                m_stale = imem_req && !imem_ack;
                m_fetch = redirect_pc;
            end else begin
                if ((m_q.size() != 0) && out_ready) begin
                    void'(m_q.pop_front());
                end
                if (imem_req && imem_ack) begin
                    if (m_stale) begin
                        m_stale = 1'b0;
                    end else begin
                        m_q.push_back(m_fetch);
                        m_fetch = m_fetch + 8'd1;
                        pushed  = 1'b1;
                    end
                end
                check("no_overflow", 32'(m_q.size() > DEPTH), 32'd0);
            end
            if (pushed || redirect_valid || (m_q.size() >= DEPTH)) begin
                m_stall = 0;
            end else begin
                m_stall++;
            end
            m_prev_pend = imem_req && !imem_ack;
            m_prev_addr = imem_addr;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1ns into cycle 0, the first cycle after the reset edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        out_ready      = 1'b1;

        // Zero-latency streaming, plus the RESET_PC=FE instance
        lat_min = 0; lat_max = 0; out_ready = 1'b1;
        do_reset();
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_pc", 32'(out_pc), 32'd0);
        check("rst_instr", 32'(out_instr), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            @(negedge clk);
            if (k == 1) begin
                check("first_req", 32'(imem_req), 32'd1);
                check("first_addr", 32'(imem_addr), 32'd0);
                check("first_valid", 32'(out_valid), 32'd0);
            end else begin
                check("stream_valid", 32'(out_valid), 32'd1);
                check("stream_pc", 32'(out_pc), 32'(k - 2));
            end
            if (k >= 2 && k <= 5) begin
                check("wrap_valid", 32'(b_valid), 32'd1);
                check("wrap_pc", 32'(b_pc), 32'((8'hFE + 8'(k - 2)) & 8'hFF));
                check("wrap_instr", 32'(b_instr), 32'(instr_of(8'hFE + 8'(k - 2))));
            end
        end

        // Backpressure: fill, stall, then drain in order
        out_ready = 1'b0;
        do_reset();
        for (int k = 1; k <= 8; k++) next_cycle();
        @(negedge clk);
        check("full_count", 32'(count), 32'd4);
        check("full_req", 32'(imem_req), 32'd0);
        check("full_addr", 32'(imem_addr), 32'd4);
        for (int j = 0; j <= 5; j++) begin
            next_cycle();
            out_ready = 1'b1;
            @(negedge clk);
            check("drain_pc", 32'(out_pc), 32'(j));
            if (j == 1) begin
                check("refetch_req", 32'(imem_req), 32'd1);
                check("refetch_addr", 32'(imem_addr), 32'd4);
            end
        end

        // Latency 3, then redirect to 40 while the fetch of 05 is pending
        lat_min = 3; lat_max = 3; out_ready = 1'b1;
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            next_cycle();
            redirect_valid = (k == 22);
            redirect_pc    = (k == 22) ? 8'h40 : 8'h00;
            @(negedge clk);
            if (k <= 13) begin
                check("lat_ack", 32'(imem_ack), 32'(k % 4 == 0));
                check("lat_addr", 32'(imem_addr), 32'((k - 1) / 4));
                check("lat_valid", 32'(out_valid), 32'(k >= 5 && k % 4 == 1));
                if (out_valid) check("lat_pc", 32'(out_pc), 32'((k - 5) / 4));
            end
            if (k == 23 || k == 24) begin
                check("squash_req", 32'(imem_req), 32'd1);
                check("squash_addr", 32'(imem_addr), 32'h05);
            end
            if (k >= 25 && k <= 28) begin
                check("target_addr", 32'(imem_addr), 32'h40);
            end
            if (k == 29) begin
                check("target_valid", 32'(out_valid), 32'd1);
                check("target_pc", 32'(out_pc), 32'h40);
            end
            if (k >= 23) begin
                check("no_stale_pc", 32'(out_valid && out_pc == 8'h05), 32'd0);
            end
        end
        redirect_valid = 1'b0;

        // Reset with a fetch outstanding and the FIFO nearly full
        lat_min = 3; lat_max = 3; out_ready = 1'b0;
        do_reset();
        for (int k = 1; k <= 15; k++) next_cycle();
        @(negedge clk);
        check("pre_rst_count", 32'(count), 32'd3);
        check("pre_rst_req", 32'(imem_req), 32'd1);
        do_reset();
        @(negedge clk);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_req", 32'(imem_req), 32'd0);
        next_cycle();
        @(negedge clk);
        check("post_rst_req", 32'(imem_req), 32'd1);
        check("post_rst_addr", 32'(imem_addr), 32'd0);

        // Randomized traffic against the scoreboard
        lat_min = 0; lat_max = 3; out_ready = 1'b1;
        do_reset();
        begin
            int mode;
            mode = 0;
            for (int k = 0; k < 3000; k++) begin
                next_cycle();
                if (k % 200 == 0) mode = int'($urandom_range(2, 0));
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = ($urandom_range(1, 0) == 0);
                    default: out_ready = ($urandom_range(9, 0) == 0);
                endcase
                redirect_valid = ($urandom_range(11, 0) == 0);
                redirect_pc    = 8'($urandom);
                rst            = ($urandom_range(299, 0) == 0);
            end
        end
        next_cycle();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
